sr_piso_unloader: RTL and testbench



---
 rtl/sr_piso_unloader_pkg.sv | 21 ++
 rtl/sr_piso_unloader_lane.sv | 32 +++
 rtl/sr_piso_unloader.sv | 97 +++++++++
 tb/tb_sr_piso_unloader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_piso_unloader_pkg.sv
// Shared types and helpers for the parallel-in / serial-out unloader.
// Optional build macro: SR_PISO_LSB_FIRST_EN selects LSB-first bit order.
package sr_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter must hold the value depth itself, hence depth+1 codes.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

`ifdef SR_PISO_LSB_FIRST_EN
   localparam bit LSB_FIRST = 1'b1;
`else
   localparam bit LSB_FIRST = 1'b0;
`endif

endpackage

// File: rtl/sr_piso_unloader_lane.sv
// One serial lane: a depth-bit register that loads in parallel and shifts
// toward its head bit. All sequencing lives in the top.
module sr_piso_lane
   import sr_pkg::*;
#(
   parameter int depth = 130
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [depth-1:0] d,
   output logic             q
);

   logic [depth-1:0] sr;

   // Load has priority so a back-to-back reload replaces the final shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= d;
      end else if (shift) begin
         if (LSB_FIRST) sr <= {1'b0, sr[depth-1:1]};
         else           sr <= {sr[depth-2:0], 1'b0};
      end
   end

   assign q = LSB_FIRST ? sr[0] : sr[depth-1];

endmodule

// File: rtl/sr_piso_unloader.sv
// Parallel-in / serial-out unloader: accepts one depth-bit word per lane over
// a valid/ready port and shifts it out one bit per lane per enabled clock.
// Optional build macro: SR_PISO_LSB_FIRST_EN (bit 0 first instead of MSB).
module sr_piso_unloader
   import sr_pkg::*;
#(
   parameter int width = 1,
   parameter int depth = 130
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [width*depth-1:0] load_data,
   input  logic                   e,
   output logic [width-1:0]       q,
   output logic                   q_valid,
   output logic                   last,
   output logic                   busy
);

   localparam int             CW       = cnt_w(depth);
   localparam logic [CW-1:0]  CNT_FULL = CW'(depth);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          at_last;
   logic          accept;
   logic          shift;

   assign at_last    = (state == SHIFT) && (cnt == CNT_ONE);
   // Ready never looks at load_valid, so the handshake has no comb loop.
   assign load_ready = (state == IDLE) || (at_last && e);
   assign accept     = load_ready && load_valid;
   assign shift      = (state == SHIFT) && e;

   assign q_valid = (state == SHIFT);
   assign busy    = (state == SHIFT);
   assign last    = at_last;

   // State and bit counter register; reset drops any word in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: count enabled shifts, reload without a bubble on the last bit.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (load_valid) begin
               state_nxt = SHIFT;
               cnt_nxt   = CNT_FULL;
            end
         end
         SHIFT: begin
            if (e) begin
               if (cnt == CNT_ONE) begin
                  if (load_valid) begin
                     cnt_nxt = CNT_FULL;
                  end else begin
                     state_nxt = IDLE;
                     cnt_nxt   = '0;
                  end
               end else if (cnt != '0) begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // One independent shift register per lane, all driven by the shared FSM.
   for (genvar g = 0; g < width; g++) begin : g_lane
      sr_piso_lane #(.depth(depth)) u_lane (
         .clk   (clk),
         .rst   (rst),
         .load  (accept),
         .shift (shift),
         .d     (load_data[g*depth +: depth]),
         .q     (q[g])
      );
   end

endmodule

// File: tb/tb_sr_piso_unloader.sv
// Bench for sr_piso_unloader: a depth=8 single-lane instance and a depth=130
// two-lane instance, checked every cycle against a word/bit-index model.
module tb_sr_piso_unloader;

`ifdef SR_PISO_LSB_FIRST_EN
   localparam bit LSB = 1'b1;
`else
   localparam bit LSB = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;

   logic         lv8 = 1'b0, e8 = 1'b0;
   logic [7:0]   ld8 = '0;
   logic         lr8, qv8, last8, busy8;
   logic [0:0]   q8;

   logic         lv130 = 1'b0, e130 = 1'b0;
   logic [259:0] ld130 = '0;
   logic         lr130, qv130, last130, busy130;
   logic [1:0]   q130;

   always #5 clk = ~clk;

   sr_piso_unloader #(.width(1), .depth(8)) u_d8 (
      .clk(clk), .rst(rst), .load_valid(lv8), .load_ready(lr8),
      .load_data(ld8), .e(e8), .q(q8), .q_valid(qv8), .last(last8), .busy(busy8)
   );

   sr_piso_unloader #(.width(2), .depth(130)) u_d130 (
      .clk(clk), .rst(rst), .load_valid(lv130), .load_ready(lr130),
      .load_data(ld130), .e(e130), .q(q130), .q_valid(qv130), .last(last130), .busy(busy130)
   );

   int nvec = 0;
   int nerr = 0;

   // Model: per instance, whether a word is in flight, how many of its bits
   // have already been consumed, and the captured word of each lane.
   bit           mact [2];
   int           mk   [2];
   logic [129:0] mw   [2][2];
   logic [129:0] rx   [2];

   task automatic check(input string tag, input logic [259:0] got, input logic [259:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int dep(input int i);
      return (i == 1) ? 130 : 8;
   endfunction

   function automatic logic [129:0] rev130(input logic [129:0] v);
      logic [129:0] r;
      for (int b = 0; b < 130; b++) r[b] = v[129-b];
      return r;
   endfunction

   task automatic capture(input int i);
      for (int w = 0; w < 2; w++) mw[i][w] = '0;
      for (int b = 0; b < dep(i); b++) begin
         if (i == 1) begin
            mw[1][0][b] = ld130[b];
            mw[1][1][b] = ld130[130+b];
         end else begin
            mw[0][0][b] = ld8[b];
         end
      end
   endtask

   task automatic check_dut(input int i);
      logic [1:0] eq;
      int         d;
      int         idx;
      d   = dep(i);
      eq  = '0;
      idx = LSB ? mk[i] : d - 1 - mk[i];
      if (mact[i]) begin
         eq[0] = mw[i][0][idx];
         eq[1] = mw[i][1][idx];
      end
      if (i == 0) begin
         check("d8_q",          q8,    eq[0]);
         check("d8_q_valid",    qv8,   mact[0]);
         check("d8_busy",       busy8, mact[0]);
         check("d8_last",       last8, mact[0] && mk[0] == 7);
         check("d8_load_ready", lr8,   !mact[0] || (mk[0] == 7 && e8));
      end else begin
         check("d130_q",          q130,    eq);
         check("d130_q_valid",    qv130,   mact[1]);
         check("d130_busy",       busy130, mact[1]);
         check("d130_last",       last130, mact[1] && mk[1] == 129);
         check("d130_load_ready", lr130,   !mact[1] || (mk[1] == 129 && e130));
      end
   endtask

   task automatic update_dut(input int i);
      logic lv, en;
      int   d;
      d  = dep(i);
      lv = (i == 1) ? lv130 : lv8;
      en = (i == 1) ? e130  : e8;
      if (rst) begin
         mact[i] = 1'b0;
         mk[i]   = 0;
         return;
      end
      if (i == 1 && mact[1] && en) begin
         for (int w = 0; w < 2; w++) rx[w] = {rx[w][128:0], q130[w]};
         if (mk[1] == 129) begin
            check("loopback_lane0", rx[0], LSB ? rev130(mw[1][0]) : mw[1][0]);
            check("loopback_lane1", rx[1], LSB ? rev130(mw[1][1]) : mw[1][1]);
         end
      end
      if (!mact[i]) begin
         if (lv) begin
            mact[i] = 1'b1;
            mk[i]   = 0;
            capture(i);
         end
      end else if (en) begin
         if (mk[i] == d - 1) begin
            if (lv) begin
               mk[i] = 0;
               capture(i);
            end else begin
               mact[i] = 1'b0;
            end
         end else begin
            mk[i]++;
         end
      end
   endtask

   // One clock: check outputs mid-cycle, advance the model, pass the edge.
   task automatic step();
      @(negedge clk);
      check_dut(0);
      check_dut(1);
      update_dut(0);
      update_dut(1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nv, nr, nb, lastpos, acc;
      mact[0] = 1'b0; mact[1] = 1'b0; mk[0] = 0; mk[1] = 0;
      rx[0] = '0; rx[1] = '0;
      for (int i = 0; i < 2; i++) for (int w = 0; w < 2; w++) mw[i][w] = '0;

      // Reset state
      step(); step();
      rst = 1'b0;
      step();

      // Single word A5, continuous enable
      ld8 = 8'hA5; lv8 = 1'b1; e8 = 1'b1;
      step();
      lv8 = 1'b0;
      nv = 0;
      for (int j = 0; j < 12; j++) begin
         if (qv8) nv++;
         step();
      end
      check("a5_valid_cycles", 32'(nv), 32'd8);

      // Back-to-back FF then 00 with load_valid held
      ld8 = 8'hFF; lv8 = 1'b1; e8 = 1'b1;
      step();
      ld8 = 8'h00;
      nv = 0; nr = 0;
      for (int j = 0; j < 16; j++) begin
         if (j == 8) lv8 = 1'b0;
         if (qv8) nv++;
         if (lr8) nr++;
         step();
      end
      check("b2b_valid_cycles", 32'(nv), 32'd16);
      check("b2b_ready_pulses", 32'(nr), 32'd2);
      check("b2b_idle_after", qv8, 1'b0);

      // load_valid during SHIFT with cnt>1 must be ignored
      ld8 = 8'h3C; lv8 = 1'b1;
      step();
      ld8 = 8'hFF;
      step(); step(); step();
      lv8 = 1'b0;
      repeat (8) step();

      // Reset mid-word after 5 bits
      ld8 = 8'h5A; lv8 = 1'b1; e8 = 1'b1;
      step();
      lv8 = 1'b0;
      repeat (5) step();
      #2 rst = 1'b1;
      #1;
      check("rst_q",          q8,    1'b0);
      check("rst_q_valid",    qv8,   1'b0);
      check("rst_busy",       busy8, 1'b0);
      check("rst_load_ready", lr8,   1'b1);
      mact[0] = 1'b0; mact[1] = 1'b0; mk[0] = 0; mk[1] = 0;
      step();
      rst = 1'b0;
      step();
      ld8 = 8'hC3; lv8 = 1'b1;
      step();
      lv8 = 1'b0;
      nv = 0;
      for (int j = 0; j < 10; j++) begin
         if (qv8) nv++;
         step();
      end
      check("fresh_valid_cycles", 32'(nv), 32'd8);
      e8 = 1'b0;

      // Stall on depth=130: e pattern 1,0,0 repeating
      for (int b = 0; b < 130; b++) begin
         ld130[b]     = (b % 3 == 0);
         ld130[130+b] = (b % 5 == 0);
      end
      lv130 = 1'b1; e130 = 1'b1;
      step();
      lv130 = 1'b0;
      nb = 0; lastpos = 0;
      for (int j = 0; j < 600 && qv130; j++) begin
         e130 = (j % 3 == 0);
         #1;
         if (qv130 && e130) begin
            nb++;
            if (last130) lastpos = nb;
         end
         step();
      end
      check("stall_bits",    32'(nb),      32'd130);
      check("stall_last_at", 32'(lastpos), 32'd130);

      // Random words with random enable, loopback into receiver chains
      for (int n = 0; n < 6; n++) begin
         for (int b = 0; b < 260; b++) ld130[b] = 1'($urandom_range(0, 1));
         lv130 = 1'b1;
         acc = 0;
         for (int t = 0; t < 800 && acc == 0; t++) begin
            e130 = ($urandom_range(0, 3) != 0);
            #1;
            if (lr130 && lv130) acc = 1;
            step();
         end
         if (acc == 0) check("accept_timeout", 1'b0, 1'b1);
         lv130 = 1'b0;
      end
      for (int t = 0; t < 800 && busy130; t++) begin
         e130 = ($urandom_range(0, 3) != 0);
         step();
      end
      check("random_drained", busy130, 1'b0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
